ram_chunk_responder: RTL and testbench

RAM_CHUNK_RESPONDER -- requirements
Module: ram_chunk_responder

---
 rtl/ram_responder_pkg.sv | 17 +
 rtl/ram_chunk_responder.sv | 159 +++++++++++++++
 tb/tb_ram_chunk_responder.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_responder_pkg.sv
// Shared defaults and FSM state encoding for the chunk-to-beat RAM responder.
package ram_responder_pkg;

    localparam int CHUNK_PART_DEF   = 128;
    localparam int DATA_SIZE_DEF    = 32;
    localparam int ADDRESS_SIZE_DEF = 28;
    localparam int BEATS            = CHUNK_PART_DEF / DATA_SIZE_DEF;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WRITE_BEAT = 3'd1,
        READ_REQ   = 3'd2,
        READ_WAIT  = 3'd3,
        DONE       = 3'd4
    } state_t;

endpackage

// File: rtl/ram_chunk_responder.sv
// Splits chunk writes/reads into ascending DATA_SIZE beats on a req/ready backend; every beat waits on mem_ready, reads also wait on mem_rvalid.
// RAM_RESPONDER_BYPASS_EN: a write+read to the same chunk returns the written data without backend reads.
module ram_chunk_responder
    import ram_responder_pkg::*;
#(
    parameter int CHUNK_PART   = CHUNK_PART_DEF,
    parameter int DATA_SIZE    = DATA_SIZE_DEF,
    parameter int ADDRESS_SIZE = ADDRESS_SIZE_DEF
) (
    input  logic                    clk,
    input  logic                    reset,

    output logic                    ram_controller_ready,
    input  logic                    ram_write_trigger,
    input  logic [CHUNK_PART-1:0]   ram_write_value,
    input  logic [ADDRESS_SIZE-1:0] ram_write_address,
    input  logic                    ram_read_trigger,
    input  logic [ADDRESS_SIZE-1:0] ram_read_address,
    output logic [CHUNK_PART-1:0]   ram_read_value,
    output logic                    ram_read_value_ready,

    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDRESS_SIZE-1:0] mem_addr,
    output logic [DATA_SIZE-1:0]    mem_wdata,
    input  logic                    mem_ready,
    input  logic                    mem_rvalid,
    input  logic [DATA_SIZE-1:0]    mem_rdata
);

    localparam int NBEATS      = CHUNK_PART / DATA_SIZE;
    localparam int BEAT_W      = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int CHUNK_ALIGN = $clog2(CHUNK_PART / 8);
    localparam int BEAT_SHIFT  = $clog2(DATA_SIZE / 8);
    localparam logic [ADDRESS_SIZE-1:0] ALIGN_MASK =
        ~((ADDRESS_SIZE'(1) << CHUNK_ALIGN) - ADDRESS_SIZE'(1));
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [BEAT_W-1:0]       r_beat;
    logic [CHUNK_PART-1:0]   r_wdata;
    logic [CHUNK_PART-1:0]   r_rbuf;
    logic [CHUNK_PART-1:0]   r_read_value;
    logic [ADDRESS_SIZE-1:0] r_waddr;
    logic [ADDRESS_SIZE-1:0] r_raddr;
    logic                    r_rd_pend;
    logic                    r_bypass;

    logic                    w_last;
    logic                    w_bypass_hit;
    logic [ADDRESS_SIZE-1:0] w_base;
    logic [CHUNK_PART-1:0]   w_rd_chunk;

    assign w_last = (r_beat == LAST_BEAT);

`ifdef RAM_RESPONDER_BYPASS_EN
    assign w_bypass_hit = ram_write_trigger && ram_read_trigger &&
        ((ram_write_address & ALIGN_MASK) == (ram_read_address & ALIGN_MASK));
`else
    assign w_bypass_hit = 1'b0;
`endif

    // Read buffer with the current beat slot replaced by the incoming word.
    always_comb begin
        w_rd_chunk = r_rbuf;
        w_rd_chunk[r_beat*DATA_SIZE +: DATA_SIZE] = mem_rdata;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (ram_write_trigger)
                    w_state_nxt = WRITE_BEAT;
                else if (ram_read_trigger)
                    w_state_nxt = READ_REQ;
            end
            WRITE_BEAT: begin
                if (mem_ready && w_last) begin
                    if (r_bypass)
                        w_state_nxt = DONE;
                    else if (r_rd_pend)
                        w_state_nxt = READ_REQ;
                    else
                        w_state_nxt = IDLE;
                end
            end
            READ_REQ: begin
                if (mem_ready)
                    w_state_nxt = READ_WAIT;
            end
            READ_WAIT: begin
                if (mem_rvalid)
                    w_state_nxt = w_last ? DONE : READ_REQ;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Reset also gates the handshake outputs combinationally so nothing leaks while it is held.
    always_comb begin
        w_base               = (r_state == WRITE_BEAT) ? r_waddr : r_raddr;
        ram_controller_ready = !reset && (r_state == IDLE);
        ram_read_value_ready = !reset && (r_state == DONE);
        mem_req              = !reset && ((r_state == WRITE_BEAT) || (r_state == READ_REQ));
        mem_we               = !reset && (r_state == WRITE_BEAT);
        mem_addr             = w_base + (ADDRESS_SIZE'(r_beat) << BEAT_SHIFT);
        mem_wdata            = r_wdata[r_beat*DATA_SIZE +: DATA_SIZE];
        ram_read_value       = r_read_value;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_beat       <= '0;
            r_wdata      <= '0;
            r_rbuf       <= '0;
            r_read_value <= '0;
            r_waddr      <= '0;
            r_raddr      <= '0;
            r_rd_pend    <= 1'b0;
            r_bypass     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    r_beat <= '0;
                    if (ram_write_trigger) begin
                        r_wdata   <= ram_write_value;
                        r_waddr   <= ram_write_address & ALIGN_MASK;
                        r_rd_pend <= ram_read_trigger;
                        r_bypass  <= w_bypass_hit;
                    end
                    if (ram_read_trigger)
                        r_raddr <= ram_read_address & ALIGN_MASK;
                end
                WRITE_BEAT: begin
                    if (mem_ready) begin
                        r_beat <= w_last ? '0 : r_beat + BEAT_W'(1);
                        if (w_last && r_bypass)
                            r_read_value <= r_wdata;
                    end
                end
                READ_WAIT: begin
                    if (mem_rvalid) begin
                        r_rbuf <= w_rd_chunk;
                        r_beat <= w_last ? '0 : r_beat + BEAT_W'(1);
                        if (w_last)
                            r_read_value <= w_rd_chunk;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_chunk_responder.sv
// Directed table plus randomized transactions against a memory-level reference model of ram_chunk_responder.
module tb_ram_chunk_responder;
    import ram_responder_pkg::*;

    localparam int CW = 128;
    localparam int DW = 32;
    localparam int AW = 28;
`ifdef RAM_RESPONDER_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          ram_controller_ready;
    logic          ram_write_trigger;
    logic [CW-1:0] ram_write_value;
    logic [AW-1:0] ram_write_address;
    logic          ram_read_trigger;
    logic [AW-1:0] ram_read_address;
    logic [CW-1:0] ram_read_value;
    logic          ram_read_value_ready;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;

    ram_chunk_responder #(.CHUNK_PART(CW), .DATA_SIZE(DW), .ADDRESS_SIZE(AW)) dut (
        .clk(clk), .reset(reset),
        .ram_controller_ready(ram_controller_ready),
        .ram_write_trigger(ram_write_trigger), .ram_write_value(ram_write_value),
        .ram_write_address(ram_write_address),
        .ram_read_trigger(ram_read_trigger), .ram_read_address(ram_read_address),
        .ram_read_value(ram_read_value), .ram_read_value_ready(ram_read_value_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] data; } acc_t;
    typedef struct { int cyc; logic [CW-1:0] val; } done_t;
    typedef struct {
        logic we; logic re; logic [AW-1:0] wa; logic [CW-1:0] wd; logic [AW-1:0] ra;
        logic [AW-1:0] st_addr; int st_n; bit poke; int busy;
    } vec_t;

    acc_t          acc_q[$];
    acc_t          exp_q[$];
    done_t         done_q[$];
    logic [DW-1:0] env_mem [int];
    logic [DW-1:0] ref_mem [int];

    int n_pass = 0, n_total = 0, cyc = 0;
    bit pend = 0, inject = 0, rnd_stall = 0, prev_stall = 0, prev_we = 0;
    logic [DW-1:0] pend_data, prev_wdata;
    logic [AW-1:0] prev_addr, stall_addr;
    int stall_left = 0, stall_cyc = 0;
    logic [CW-1:0] last_rd = '0;

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
        return {a[AW-1:4], 4'h0};
    endfunction

    function automatic logic [DW-1:0] env_read(input logic [AW-1:0] a);
        return env_mem.exists(int'(a)) ? env_mem[int'(a)] : init_word(a);
    endfunction

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_word(a);
    endfunction

    task automatic chk(input string name, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // One clock: sample DUT at the falling edge and act as the backend for this cycle.
    task automatic cycle();
        @(negedge clk);
        cyc++;
        if (prev_stall)
            chk("mem_hold", {mem_req, mem_we, mem_addr, mem_wdata},
                {1'b1, prev_we, prev_addr, prev_wdata});
        mem_rvalid = pend | inject;
        mem_rdata  = pend ? pend_data : 32'hDEAD_BEEF;
        pend = 0;
        if (ram_read_value_ready) done_q.push_back('{cyc, ram_read_value});
        mem_ready = 1'b1;
        if (mem_req && mem_we && stall_left > 0 && mem_addr == stall_addr) begin
            mem_ready = 1'b0;
            stall_left--;
        end else if (rnd_stall && $urandom_range(0, 3) == 0) begin
            mem_ready = 1'b0;
        end
        prev_stall = mem_req && !mem_ready;
        prev_we    = mem_we;
        prev_addr  = mem_addr;
        prev_wdata = mem_wdata;
        if (prev_stall) stall_cyc++;
        if (mem_req && mem_ready) begin
            if (mem_we) begin
                env_mem[int'(mem_addr)] = mem_wdata;
                acc_q.push_back('{1'b1, mem_addr, mem_wdata});
            end else begin
                pend = 1;
                pend_data = env_read(mem_addr);
                acc_q.push_back('{1'b0, mem_addr, '0});
            end
        end
    endtask

    task automatic run_txn(input string tag, input logic we, input logic re,
                           input logic [AW-1:0] wa, input logic [CW-1:0] wd,
                           input logic [AW-1:0] ra, input bit poke, input int busy_fixed);
        logic          bypass;
        logic [CW-1:0] exp_val;
        logic [AW-1:0] a;
        int            busy, exp_busy, t0, mism;
        bypass  = BYP && we && re && (align(wa) == align(ra));
        exp_val = '0;
        exp_q.delete(); acc_q.delete(); done_q.delete();
        stall_cyc = 0;
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                a = align(wa) + AW'(4 * i);
                exp_q.push_back('{1'b1, a, wd[32*i +: 32]});
                ref_mem[int'(a)] = wd[32*i +: 32];
            end
        end
        if (re) begin
            if (bypass) exp_val = wd;
            else begin
                for (int i = 0; i < 4; i++) begin
                    a = align(ra) + AW'(4 * i);
                    exp_q.push_back('{1'b0, a, '0});
                    exp_val[32*i +: 32] = ref_read(a);
                end
            end
            last_rd = exp_val;
        end
        exp_busy = (busy_fixed >= 0) ? busy_fixed
                 : (we ? 4 : 0) + (re ? (bypass ? 1 : 9) : 0);

        ram_write_trigger = we; ram_read_trigger = re;
        ram_write_value = wd; ram_write_address = wa; ram_read_address = ra;
        t0 = cyc;
        busy = -1;
        for (int k = 1; k <= 200; k++) begin
            cycle();
            ram_write_trigger = poke && (k == 2);
            ram_read_trigger  = poke && (k == 2);
            ram_write_value   = ~wd;
            ram_write_address = 28'h0FF_FF00 ^ wa;
            ram_read_address  = 28'h0AB_CD00 ^ ra;
            if (ram_controller_ready) begin
                busy = k - 1;
                break;
            end
        end
        ram_write_trigger = 0; ram_read_trigger = 0;
        if (busy_fixed < 0) exp_busy += stall_cyc;

        chk($sformatf("%s_busy", tag), CW'(busy), CW'(exp_busy));
        chk($sformatf("%s_done_cnt", tag), CW'(done_q.size()), CW'(re ? 1 : 0));
        if (re && done_q.size() > 0) begin
            chk($sformatf("%s_done_lat", tag), CW'(done_q[0].cyc - t0), CW'(exp_busy));
            chk($sformatf("%s_rd_value", tag), done_q[0].val, exp_val);
        end
        chk($sformatf("%s_acc_cnt", tag), CW'(acc_q.size()), CW'(exp_q.size()));
        mism = 0;
        for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++)
            if (acc_q[i] != exp_q[i]) mism++;
        chk($sformatf("%s_acc_order", tag), CW'(mism), CW'(0));
        chk($sformatf("%s_rd_hold", tag), ram_read_value, last_rd);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b0, 1'b1, 28'h0, 128'h0, 28'h0000013, 28'h0, 0, 1'b0, 9};
        vecs[1] = '{1'b1, 1'b1, 28'h0000040, 128'h44444444_33333333_22222222_11111111,
                    28'h0000080, 28'h0, 0, 1'b0, 13};
        vecs[2] = '{1'b1, 1'b0, 28'h0000200, 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000,
                    28'h0, 28'h0000204, 3, 1'b0, 7};
        vecs[3] = '{1'b1, 1'b0, 28'h000020F, 128'h0BAD0004_0BAD0003_0BAD0002_0BAD0001,
                    28'h0, 28'h0, 0, 1'b0, 4};
        vecs[4] = '{1'b0, 1'b1, 28'h0, 128'h0, 28'h0000207, 28'h0, 0, 1'b0, 9};
        vecs[5] = '{1'b1, 1'b1, 28'h0000100, 128'h13579BDF_2468ACE0_FEDCBA98_76543210,
                    28'h000010C, 28'h0, 0, 1'b0, BYP ? 5 : 13};
        vecs[6] = '{1'b0, 1'b1, 28'h0, 128'h0, 28'h0000045, 28'h0, 0, 1'b1, 9};
        vecs[7] = '{1'b1, 1'b1, 28'h00003F0, 128'h01234567_89ABCDEF_00FF00FF_A5A5A5A5,
                    28'h0000500, 28'h0, 0, 1'b1, 13};

        reset = 1; ram_write_trigger = 0; ram_read_trigger = 0;
        ram_write_value = '0; ram_write_address = '0; ram_read_address = '0;
        mem_ready = 1; mem_rvalid = 0; mem_rdata = '0;
        cycle(); cycle();
        chk("rst_ready", CW'(ram_controller_ready), CW'(0));
        chk("rst_req_we", CW'({mem_req, mem_we}), CW'(0));
        chk("rst_rvr", CW'(ram_read_value_ready), CW'(0));
        chk("rst_value", ram_read_value, '0);
        reset = 0;
        cycle();
        chk("rst_release_ready", CW'(ram_controller_ready), CW'(1));

        for (int v = 0; v < 8; v++) begin
            stall_addr = vecs[v].st_addr;
            stall_left = vecs[v].st_n;
            run_txn($sformatf("vec%0d", v), vecs[v].we, vecs[v].re, vecs[v].wa,
                    vecs[v].wd, vecs[v].ra, vecs[v].poke, vecs[v].busy);
            stall_left = 0;
            cycle();
        end

        // Reset while waiting for beat 2 of a read; stray rvalids afterwards must be ignored.
        done_q.delete();
        ram_read_address = 28'h0000300; ram_read_trigger = 1;
        for (int k = 1; k <= 6; k++) begin
            cycle();
            ram_read_trigger = 0;
        end
        reset = 1;
        inject = 1;
        cycle();
        chk("midrst_ready", CW'(ram_controller_ready), CW'(0));
        chk("midrst_req", CW'(mem_req), CW'(0));
        chk("midrst_value", ram_read_value, '0);
        reset = 0;
        cycle();
        chk("midrst_release_ready", CW'(ram_controller_ready), CW'(1));
        chk("midrst_release_req", CW'(mem_req), CW'(0));
        inject = 0;
        cycle(); cycle();
        chk("midrst_no_done", CW'(done_q.size()), CW'(0));
        last_rd = '0;
        run_txn("post_rst_read", 1'b0, 1'b1, '0, '0, 28'h0000300, 1'b0, 9);

        for (int t = 0; t < 40; t++) begin
            logic [AW-1:0] wa, ra;
            logic [CW-1:0] wd;
            int kind;
            kind = $urandom_range(0, 3);
            wa = 28'h0001000 + AW'($urandom_range(0, 7) * 16) + AW'($urandom_range(0, 15));
            ra = 28'h0001000 + AW'($urandom_range(0, 7) * 16) + AW'($urandom_range(0, 15));
            if (kind == 3) ra = align(wa) + AW'($urandom_range(0, 15));
            wd = {$urandom(), $urandom(), $urandom(), $urandom()};
            rnd_stall = ($urandom_range(0, 1) == 1);
            run_txn($sformatf("rnd%0d", t), kind != 0, kind != 1, wa, wd, ra,
                    $urandom_range(0, 4) == 0, -1);
            rnd_stall = 0;
            for (int g = $urandom_range(0, 2); g > 0; g--) cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
